// File: rtl/rr_logic_arb_pkg.sv
// Shared definitions for the round-robin logic-unit arbiter: operation
// encoding, result-register state encoding, default sizes and the bitwise
// function evaluated by the shared datapath.
package rr_logic_arb_pkg;

  // Default configuration of the arbiter.
  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 8;

  // Widest operand the shared function handles; callers zero-extend their
  // operands to this width and size-cast the result back down.
  localparam int MAX_W = 64;

  // Operation encoding carried on each requester's 2-bit op slice.
  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  // Result register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Bitwise result of one operation. NAND inverts every bit of the operand
  // width, so the caller's size cast keeps exactly W inverted bits.
  function automatic logic [MAX_W-1:0] logic_op(
    input op_e              fn,
    input logic [MAX_W-1:0] x,
    input logic [MAX_W-1:0] y
  );
    logic [MAX_W-1:0] r;
    unique case (fn)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker. Scans the request vector upward from the
// pointer, wrapping modulo N_REQ, and returns the first asserted request as a
// one-hot grant plus its index. A pointer held at zero gives fixed priority
// with the lowest index winning.
module rr_pick
  import rr_logic_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any_req
);

  logic            found;
  logic [ID_W-1:0] cand;

  // Rotating first-one search starting at the pointer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch.
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    cand    = '0;
    any_req = |req;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/rr_logic_arbiter.sv
// Arbiter sharing one registered bitwise logic unit (AND/OR/XOR/NAND) among
// N_REQ requesters. One request is launched per cycle when the result register
// is empty or being drained; its result appears one cycle later with the
// winner's id under a valid/ready handshake.
//
// Build option: define RR_LOGIC_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no rotating pointer). Undefined, the grant rotates round-robin.
module rr_logic_arbiter
  import rr_logic_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] op,
  input  logic [W*N_REQ-1:0] a,
  input  logic [W*N_REQ-1:0] b,
  output logic [N_REQ-1:0]   gnt,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ID_W-1:0]    res_id,
  output logic [W-1:0]       res_data,
  output logic               busy
);

  state_e           state;
  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]  pick_idx;
  logic             any_req;
  logic             can_issue;
  logic             launch;
  logic [1:0]       sel_op;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic [W-1:0]     res_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt     (pick_gnt),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  // The result register can take a new value when empty or drained this
  // cycle; nothing launches while reset is held.
  assign can_issue = (state == ST_EMPTY) | res_ready;
  assign launch    = ~rst & can_issue & any_req;
  assign gnt       = launch ? pick_gnt : '0;

  // Route the winner's op and operands to the shared unit (one-hot select).
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_op = op[2*i +: 2];
        sel_a  = a[W*i +: W];
        sel_b  = b[W*i +: W];
      end
    end
  end

  assign res_next = W'(logic_op(op_e'(sel_op), MAX_W'(sel_a), MAX_W'(sel_b)));

`ifdef RR_LOGIC_ARB_FIXED_PRIO_EN
  // Fixed priority: the scan always starts at requester 0.
  assign ptr = '0;
`else
  // Advance the pointer past each winner so it has lowest priority next.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      ptr <= '0;
    end else if (launch) begin
      ptr <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
    end
  end
`endif

  // Result register FSM: load on launch, empty on handshake without launch,
  // hold everything while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      res_id   <= '0;
      res_data <= '0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (launch) begin
            state    <= ST_FULL;
            res_id   <= pick_idx;
            res_data <= res_next;
          end
        end
        ST_FULL: begin
          if (launch) begin
            res_id   <= pick_idx;
            res_data <= res_next;
          end else if (res_ready) begin
            state <= ST_EMPTY;
          end
        end
      endcase
    end
  end

  assign res_valid = (state == ST_FULL);
  assign busy      = res_valid | any_req;

endmodule

// File: tb/tb_rr_logic_arbiter.sv
// Self-checking bench for rr_logic_arbiter. A driver applies directed and
// random requests and predicts grants and results from a behavioural model;
// expected results go into a scoreboard queue that a separate monitor pops on
// every result handshake.
module tb_rr_logic_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int ID_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [2*N-1:0]   op;
  logic [W*N-1:0]   a;
  logic [W*N-1:0]   b;
  logic [N-1:0]     gnt;
  logic             res_valid;
  logic             res_ready;
  logic [ID_W-1:0]  res_id;
  logic [W-1:0]     res_data;
  logic             busy;

  rr_logic_arbiter #(.N_REQ(N), .W(W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [W-1:0] data;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  // Requester-side stimulus state.
  logic [1:0]   t_op[N];
  logic [W-1:0] t_a[N];
  logic [W-1:0] t_b[N];
  logic [N-1:0] t_req;
  logic         t_rdy;

  // Model state.
  int m_ptr;
  bit m_valid;
  int last_w;
  bit in_reset;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_op(input int fn, input logic [W-1:0] x, input logic [W-1:0] y);
    case (fn)
      0:       return x & y;
      1:       return x | y;
      2:       return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  // Winner = pending requester at the smallest upward distance from the
  // pointer (fixed priority is the same rule with the pointer at zero).
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    int best   = -1;
    int best_d = N;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        int d = (i - p + N) % N;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  task automatic drive();
    req       = t_req;
    res_ready = t_rdy;
    for (int i = 0; i < N; i++) begin
      op[2*i +: 2] = t_op[i];
      a[W*i +: W]  = t_a[i];
      b[W*i +: W]  = t_b[i];
    end
  endtask

  // One clock cycle: apply stimulus, check the combinational grant and the
  // result-register state against the model, then advance the model.
  task automatic step();
    int           w;
    logic [N-1:0] exp_gnt;
    exp_t         e;
    @(negedge clk);
    drive();
    #1;
    w       = (!m_valid || t_rdy) ? model_pick(t_req, m_ptr) : -1;
    exp_gnt = '0;
    if (w >= 0) exp_gnt[w] = 1'b1;
    check("gnt", gnt, exp_gnt);
    check("res_valid", res_valid, m_valid);
    check("busy", busy, m_valid | (|t_req));
    last_w = w;
    if (w >= 0) begin
      e.id   = w;
      e.data = model_op(t_op[w], t_a[w], t_b[w]);
      sb_q.push_back(e);
      m_valid = 1'b1;
`ifndef RR_LOGIC_ARB_FIXED_PRIO_EN
      m_ptr = (w + 1) % N;
`endif
    end else if (m_valid && t_rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // Monitor: every handshake delivers the oldest expected result.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!in_reset && res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: result id %0d data 0x%0h with none expected", res_id, res_data);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_res_id", res_id, e.id);
          check("sb_res_data", res_data, e.data);
        end
      end
    end
  end

  logic [1:0]   op_tab[3]  = '{2'd2, 2'd3, 2'd1};
  logic [W-1:0] a_tab[3]   = '{8'hAA, 8'hFF, 8'h01};
  logic [W-1:0] b_tab[3]   = '{8'hFF, 8'h0F, 8'h80};
  logic [W-1:0] exp_tab[3] = '{8'h55, 8'hF0, 8'h81};

  initial begin
    int           held_id;
    logic [W-1:0] held_data;
    rst      = 1'b1;
    in_reset = 1'b1;
    m_ptr    = 0;
    m_valid  = 1'b0;
    last_w   = -1;
    t_req    = '0;
    t_rdy    = 1'b1;
    for (int i = 0; i < N; i++) begin
      t_op[i] = '0;
      t_a[i]  = '0;
      t_b[i]  = '0;
    end
    drive();
    req = '1;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_valid", res_valid, 0);
    check("rst_id", res_id, 0);
    check("rst_data", res_data, 0);
    @(negedge clk);
    rst = 1'b0;
    drive();
    #1;
    check("idle_busy", busy, 0);
    in_reset = 1'b0;

    // Single AND op.
    t_req = 4'b0001; t_op[0] = 2'd0; t_a[0] = 8'hF0; t_b[0] = 8'h3C;
    step();
    check("single_gnt", gnt, 4'b0001);
    t_req = '0;
    step();
    check("single_valid", res_valid, 1);
    check("single_id", res_id, 0);
    check("single_data", res_data, 8'h30);

    // Reset while a result is pending.
    t_req = 4'b0010; t_op[1] = 2'd2; t_a[1] = 8'h5A; t_b[1] = 8'hFF;
    step();
    t_req = '0;
    @(negedge clk);
    in_reset = 1'b1;
    t_rdy = 1'b0;
    drive();
    #1;
    check("pre_rst_valid", res_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_id", res_id, 0);
    check("mid_rst_data", res_data, 0);
    req = 4'b1111;
    #1;
    check("mid_rst_gnt", gnt, 0);
    sb_q.delete();
    m_valid = 1'b0;
    m_ptr   = 0;
    @(negedge clk);
    rst   = 1'b0;
    t_rdy = 1'b1;
    drive();
    #1;
    check("post_rst_busy", busy, 0);
    in_reset = 1'b0;

    for (int i = 0; i < N; i++) begin
      t_op[i] = 2'(i);
      t_a[i]  = 8'h3C ^ W'(i * 8'h11);
      t_b[i]  = 8'hA5 + W'(i);
    end
`ifdef RR_LOGIC_ARB_FIXED_PRIO_EN
    // Lowest index always wins; requester 3 waits until requester 1 drops.
    t_req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      check("fixed_gnt", gnt, 4'b0010);
    end
    t_req[1] = 1'b0;
    step();
    check("fixed_gnt_after_drop", gnt, 4'b1000);
`else
    // Round-robin rotation with all requesters held.
    t_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_gnt", gnt, 32'(1 << (k % 4)));
      if (k > 0) check("rr_id", res_id, (k - 1) % 4);
    end
`endif

    // Backpressure: pending result held while the consumer stalls.
    held_id   = last_w;
    held_data = model_op(t_op[held_id], t_a[held_id], t_b[held_id]);
    t_req = 4'b0100;
    t_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_gnt", gnt, 0);
      check("stall_id", res_id, held_id);
      check("stall_data", res_data, held_data);
    end
    t_rdy = 1'b1;
    step();
    check("unstall_gnt", gnt, 4'b0100);
    t_req = '0;
    step();
    check("unstall_id", res_id, 2);
    check("unstall_data", res_data, model_op(t_op[2], t_a[2], t_b[2]));

    // Individual operations.
    for (int j = 0; j < 3; j++) begin
      t_req = 4'b0001; t_op[0] = op_tab[j]; t_a[0] = a_tab[j]; t_b[0] = b_tab[j];
      step();
      t_req = '0;
      step();
      check("op_data", res_data, exp_tab[j]);
    end

    // Random traffic following the requester rules.
    t_req = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!t_req[i] && $urandom_range(0, 2) == 0) begin
          t_req[i] = 1'b1;
          t_op[i]  = 2'($urandom_range(0, 3));
          t_a[i]   = W'($urandom);
          t_b[i]   = W'($urandom);
        end else if (t_req[i] && $urandom_range(0, 19) == 0) begin
          t_req[i] = 1'b0;
        end
      end
      t_rdy = ($urandom_range(0, 3) != 0);
      step();
      if (last_w >= 0) begin
        if ($urandom_range(0, 1) == 1) begin
          t_op[last_w] = 2'($urandom_range(0, 3));
          t_a[last_w]  = W'($urandom);
          t_b[last_w]  = W'($urandom);
        end else begin
          t_req[last_w] = 1'b0;
        end
      end
    end

    // Drain and confirm every expected result was delivered.
    t_req = '0;
    t_rdy = 1'b1;
    repeat (3) step();
    check("sb_empty", sb_q.size(), 0);
    check("drain_valid", res_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
